// File: rtl/arb_pkg.sv
// arb_pkg: shared arbiter types and helper functions
package arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [31:0] idx2oh(input int i);
    return 32'(1) << i;
  endfunction
  function automatic int oh2idx(input logic [31:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if (oh[i]) r = i;
    return r;
  endfunction
endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational winner search, fixed (highest index) or round-robin after ptr
module arb_pick
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   cand,
  input  logic           mode,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   win_oh,
  output logic [IDW-1:0] win_id,
  output logic           any
);
  logic [2*N-1:0] dbl;
  logic [IDW-1:0] fx_id, rr_id;
  always_comb begin
    dbl = {cand, cand};
    fx_id = '0;
    rr_id = '0;
    for (int j = 0; j < N; j++) if (cand[j]) fx_id = IDW'(j);
    // doubled vector windowed to (ptr, ptr+N]; lowest surviving bit is the next in rotation
    for (int j = 2*N-1; j >= 0; j--)
      if (dbl[j] && j > int'(ptr) && j <= int'(ptr) + N) rr_id = IDW'(j % N);
    any = |cand;
    win_id = mode ? rr_id : fx_id;
    win_oh = any ? N'(idx2oh(int'(win_id))) : '0;
  end
endmodule

// File: rtl/param_priority_arbiter.sv
// param_priority_arbiter: N-way locking arbiter, fixed or round-robin, with hold-time limit
module param_priority_arbiter
  import arb_pkg::*;
#(
  parameter int N = 4,
  parameter int MAX_HOLD = 8,
  localparam int IDW = clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);
  localparam int HW = (MAX_HOLD > 0) ? clog2(MAX_HOLD + 1) : 1;
  arb_state_t state;
  logic [HW-1:0] hold_cnt;
  logic [IDW-1:0] rr_ptr, win_id;
  logic [N-1:0] cand, win_oh;
  logic any, owner_req, others, expire, rotate;
  always_comb begin
    owner_req = |(req & gnt);
    others = |(req & ~gnt);
    expire = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
    rotate = owner_req && expire && others;
    cand = rotate ? (req & ~gnt) : req;
  end
  arb_pick #(.N(N), .IDW(IDW)) u_pick (
    .cand(cand),
    .mode(mode),
    .ptr(rr_ptr),
    .win_oh(win_oh),
    .win_id(win_id),
    .any(any)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ARB_IDLE;
      gnt <= '0;
      gnt_id <= '0;
      gnt_valid <= 1'b0;
      hold_cnt <= '0;
      rr_ptr <= IDW'(N - 1);
    end else if (state == ARB_IDLE || !owner_req || rotate) begin
      state <= any ? ARB_BUSY : ARB_IDLE;
      gnt <= win_oh;
      gnt_id <= win_id;
      gnt_valid <= any;
      hold_cnt <= any ? HW'(1) : '0;
      if (any) rr_ptr <= win_id;
    end else if (expire) begin
      hold_cnt <= HW'(1);
    end else if (MAX_HOLD != 0) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
endmodule

// File: tb/tb_param_priority_arbiter.sv
// tb_param_priority_arbiter: directed vectors across several MAX_HOLD settings
module tb_param_priority_arbiter;
  import arb_pkg::*;
  localparam int MH [5] = '{0, 2, 3, 4, 8};
  typedef struct {
    logic [3:0] req;
    logic       mode;
    logic [3:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mode = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] gnt_a [5];
  logic [1:0] id_a [5];
  logic vld_a [5];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 5; g++) begin : g_dut
    param_priority_arbiter #(.N(4), .MAX_HOLD(MH[g])) u_dut (
      .clk(clk),
      .reset(reset),
      .req(req),
      .mode(mode),
      .gnt(gnt_a[g]),
      .gnt_id(id_a[g]),
      .gnt_valid(vld_a[g])
    );
  end
  task automatic chk(input string name, input int u, input logic [3:0] exp);
    logic [1:0] eid;
    logic ev;
    eid = 2'(oh2idx(32'(exp)));
    ev = |exp;
    checks++;
    if (gnt_a[u] !== exp || id_a[u] !== eid || vld_a[u] !== ev) begin
      errors++;
      $display("FAIL %s: got gnt=%b id=%0d valid=%b, want gnt=%b id=%0d valid=%b",
               name, gnt_a[u], id_a[u], vld_a[u], exp, eid, ev);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    req = '0;
    mode = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask
  vec_t tbl [12];
  logic [3:0] rr_seq [9];
  initial begin
    tbl = '{
      '{4'b0000, 1'b0, 4'b0000},
      '{4'b0110, 1'b0, 4'b0100},
      '{4'b1110, 1'b0, 4'b0100},
      '{4'b1010, 1'b0, 4'b1000},
      '{4'b1011, 1'b1, 4'b1000},
      '{4'b0011, 1'b1, 4'b0001},
      '{4'b0010, 1'b1, 4'b0010},
      '{4'b1001, 1'b1, 4'b1000},
      '{4'b0000, 1'b1, 4'b0000},
      '{4'b0101, 1'b1, 4'b0001},
      '{4'b0100, 1'b0, 4'b0100},
      '{4'b0000, 1'b0, 4'b0000}
    };
    rr_seq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    do_reset();
    // reset state and async clear mid-grant
    chk("reset_state", 4, 4'b0000);
    req = 4'b1000;
    step();
    chk("pre_reset_grant", 4, 4'b1000);
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_clear", 4, 4'b0000);
    #1;
    reset = 1'b1;
    req = '0;
    step();
    chk("after_reset_idle", 4, 4'b0000);
    // table-driven mixed-mode sequence on MAX_HOLD=8
    do_reset();
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      mode = tbl[i].mode;
      step();
      chk($sformatf("tbl[%0d]", i), 4, tbl[i].exp);
    end
    // locking with unlimited hold, then handoff with no idle gap
    do_reset();
    req = 4'b0111;
    step();
    chk("lock_first", 0, 4'b0100);
    req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("lock_hold[%0d]", i), 0, 4'b0100);
    end
    req = 4'b1011;
    step();
    chk("lock_handoff", 0, 4'b1000);
    // round-robin rotation forced by hold limit 2
    do_reset();
    mode = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("rr_seq[%0d]", i), 1, rr_seq[i]);
    end
    // lone requester keeps grant across hold windows
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("solo[%0d]", i), 3, 4'b0001);
    end
    // release to idle then re-grant
    do_reset();
    req = 4'b0010;
    step();
    chk("rel_owner1", 4, 4'b0010);
    req = 4'b0000;
    step();
    chk("rel_idle", 4, 4'b0000);
    req = 4'b0101;
    step();
    chk("rel_regrant", 4, 4'b0100);
    // mode switch keeps owner until hold expiry, then fixed pick with owner masked
    do_reset();
    mode = 1'b1;
    req = 4'b0100;
    step();
    chk("sw_own2", 2, 4'b0100);
    mode = 1'b0;
    req = 4'b1111;
    step();
    chk("sw_hold2", 2, 4'b0100);
    step();
    chk("sw_hold3", 2, 4'b0100);
    step();
    chk("sw_rotate", 2, 4'b1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
